// File: rtl/router_pkg.sv
// Shared packet definitions for the router and its ingress feeder.
// Field positions and destination addresses live here so both decode them identically.
package router_pkg;

    localparam int PKT_W   = 43;
    localparam int CNT_HI  = 42;
    localparam int CNT_LO  = 40;
    localparam int ADDR_HI = 39;
    localparam int ADDR_LO = 24;

    // Destination addresses as {high byte, low byte}.
    localparam logic [15:0] ADDR_0 = {8'd188, 8'd39};
    localparam logic [15:0] ADDR_1 = {8'd170, 8'd153};
    localparam logic [15:0] ADDR_2 = {8'd83,  8'd168};
    localparam logic [15:0] ADDR_3 = {8'd104, 8'd148};

    typedef logic [PKT_W-1:0] pkt_t;

    // A packet is routable when it asks for at least one copy and targets a known port.
    function automatic logic pkt_is_valid(input pkt_t pkt);
        logic [2:0]  cnt;
        logic [15:0] addr;
        cnt  = pkt[CNT_HI:CNT_LO];
        addr = pkt[ADDR_HI:ADDR_LO];
        return (cnt != 3'd0) &&
               (addr == ADDR_0 || addr == ADDR_1 || addr == ADDR_2 || addr == ADDR_3);
    endfunction

endpackage

// File: rtl/packet_fifo.sv
// Generic in-order FIFO: storage, wrapping pointers, occupancy counter and head read.
// Push is ignored when full and pop is ignored when empty, both judged on pre-edge state.
module packet_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 43
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (occupancy == DEPTH_C);
    assign empty   = (occupancy == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // NOTE: the storage array has no reset; an entry is only ever read after it has been
    // written, and leaving it unreset lets it map onto plain RAM/register-file cells.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                occupancy <= occupancy + 1'b1;
            end else if (do_pop && !do_push) begin
                occupancy <= occupancy - 1'b1;
            end
        end
    end

endmodule

// File: rtl/packet_feeder.sv
// Ingress stage in front of the 4-channel router: filters malformed packets, counts
// rejections, queues good packets and presents the head (or an all-zero dummy) to the router.
module packet_feeder
    import router_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [PKT_W-1:0]         in_data,
    output logic                     in_ready,
    input  logic                     rtr_ready,
    output logic [PKT_W-1:0]         data_out,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic [7:0]               drop_count
);

    pkt_t head;
    logic handshake;
    logic pkt_ok;

    // Rejected packets still complete the handshake so bad data never stalls the producer.
    assign in_ready  = !full;
    assign handshake = in_valid && in_ready;
    assign pkt_ok    = pkt_is_valid(in_data);

    packet_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (PKT_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (handshake && pkt_ok),
        .push_data (in_data),
        .pop       (rtr_ready),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .occupancy (occupancy)
    );

    assign data_out = empty ? '0 : head;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_count <= '0;
        end else if (handshake && !pkt_ok && drop_count != 8'hFF) begin
            drop_count <= drop_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_packet_feeder.sv
// Directed bench for packet_feeder: reset, filtering, fill/drain with wrap,
// simultaneous push/pop, drop-count saturation and mid-stream reset.
`timescale 1ns/1ps
module tb_packet_feeder;
    import router_pkg::*;

    localparam int DEPTH = 8;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   in_valid;
    logic [PKT_W-1:0]       in_data;
    logic                   in_ready;
    logic                   rtr_ready;
    logic [PKT_W-1:0]       data_out;
    logic                   full;
    logic                   empty;
    logic [$clog2(DEPTH):0] occupancy;
    logic [7:0]             drop_count;

    int n_checks = 0;
    int n_fail   = 0;

    packet_feeder #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .rtr_ready  (rtr_ready),
        .data_out   (data_out),
        .full       (full),
        .empty      (empty),
        .occupancy  (occupancy),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    function automatic pkt_t mk(input logic [2:0] cnt, input logic [15:0] addr, input logic [23:0] pay);
        return {cnt, addr, pay};
    endfunction

    // Advance one edge, then settle so outputs are sampled away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_pkt(input pkt_t p);
        in_valid = 1'b1;
        in_data  = p;
        tick();
        in_valid = 1'b0;
    endtask

    logic [15:0] addrs [4];
    pkt_t        pk    [8];
    pkt_t        p;

    initial begin
        addrs[0] = ADDR_0; addrs[1] = ADDR_1; addrs[2] = ADDR_2; addrs[3] = ADDR_3;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; rtr_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();

        // Make state non-trivial, then assert reset asynchronously mid-cycle.
        push_pkt(mk(3'd1, ADDR_1, 24'h111111));
        push_pkt(mk(3'd0, ADDR_1, 24'h222222));
        check("pre_rst_occ", occupancy, 1);
        check("pre_rst_drop", drop_count, 1);
        #2 rst = 1'b1;
        #1;
        check("rst_data_out", data_out, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_drop", drop_count, 0);
        check("rst_occ", occupancy, 0);
        tick();
        rst = 1'b0;
        tick();

        // Single push with router busy, then ready.
        p = mk(3'd2, ADDR_0, 24'hABCDEF);
        push_pkt(p);
        check("single_data", data_out, p);
        check("single_occ", occupancy, 1);
        tick();
        check("single_hold", data_out, p);
        rtr_ready = 1'b1;
        tick();
        rtr_ready = 1'b0;
        check("single_popped", data_out, 0);
        check("single_empty", empty, 1);

        // Rejection: zero count, unknown address, then a good packet.
        push_pkt(mk(3'd0, ADDR_0, 24'h000001));
        push_pkt(mk(3'd1, 16'h0102, 24'h000002));
        p = mk(3'd1, ADDR_1, 24'h000003);
        push_pkt(p);
        check("rej_drop", drop_count, 2);
        check("rej_occ", occupancy, 1);
        check("rej_head", data_out, p);
        rtr_ready = 1'b1;
        tick();
        rtr_ready = 1'b0;
        check("rej_only_one", empty, 1);

        // Fill to DEPTH starting from pointer 2 so the drain crosses the wrap.
        for (int i = 0; i < 8; i++) begin
            pk[i] = mk(3'(i % 7 + 1), addrs[i % 4], 24'(32'h100 + i));
            push_pkt(pk[i]);
        end
        check("fill_full", full, 1);
        check("fill_in_ready", in_ready, 0);
        check("fill_occ", occupancy, 8);
        push_pkt(mk(3'd1, ADDR_2, 24'hDEAD00));
        check("fill_9th_occ", occupancy, 8);
        check("fill_9th_drop", drop_count, 2);
        check("fill_9th_head", data_out, pk[0]);
        rtr_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("drain_%0d", i), data_out, pk[i]);
            tick();
        end
        rtr_ready = 1'b0;
        check("drain_empty", empty, 1);
        check("drain_dummy", data_out, 0);

        // Simultaneous push and pop at occupancy 3.
        for (int i = 0; i < 3; i++) begin
            pk[i] = mk(3'd1, addrs[(i + 1) % 4], 24'(32'h200 + i));
            push_pkt(pk[i]);
        end
        pk[3] = mk(3'd4, ADDR_3, 24'h000203);
        in_valid = 1'b1; in_data = pk[3]; rtr_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check("pp_occ", occupancy, 3);
        for (int i = 1; i < 4; i++) begin
            check($sformatf("pp_order_%0d", i), data_out, pk[i]);
            tick();
        end
        check("pp_drained", empty, 1);

        // Push and pop at empty: the pop is suppressed.
        p = mk(3'd3, ADDR_2, 24'h5A5A5A);
        in_valid = 1'b1; in_data = p;
        tick();
        in_valid = 1'b0;
        check("empty_pp_occ", occupancy, 1);
        check("empty_pp_data", data_out, p);
        tick();
        rtr_ready = 1'b0;
        check("empty_pp_popped", empty, 1);

        // Drop counter saturation.
        in_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            in_data = mk(3'd0, addrs[i % 4], 24'(i));
            tick();
        end
        in_valid = 1'b0;
        check("sat_drop", drop_count, 255);
        check("sat_occ", occupancy, 0);

        // Reset mid-stream with 5 queued.
        for (int i = 0; i < 5; i++) begin
            push_pkt(mk(3'd1, addrs[i % 4], 24'(32'h300 + i)));
        end
        check("mid_occ", occupancy, 5);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_occ", occupancy, 0);
        check("mid_rst_drop", drop_count, 0);
        check("mid_rst_data", data_out, 0);
        #2 rst = 1'b0;
        tick();
        p = mk(3'd2, ADDR_3, 24'hC0FFEE);
        push_pkt(p);
        check("resume_occ", occupancy, 1);
        check("resume_data", data_out, p);
        check("resume_drop", drop_count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
